// File: rtl/calc_pkg.sv
// Shared definitions for the calculator result checker.
// Contents: op-code and seven-segment pattern constants, the decoded symbol kind,
// the FSM state encoding, and the golden-model function calc_golden.
package calc_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 5;
  localparam int unsigned SEG_W  = 7;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_NEG = 3'b010;
  localparam logic [OP_W-1:0] OP_ABS = 3'b011;

  // Active-low gfedcba segment patterns
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {
    KIND_DIGIT,
    KIND_MINUS,
    KIND_BLANK,
    KIND_E
  } seg_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REPORT
  } state_e;

  typedef struct packed {
    logic                    ovf;
    logic signed [RES_W-1:0] value;
  } golden_t;

  // Reference result in 5-bit signed arithmetic; reserved ops return zero.
  function automatic golden_t calc_golden(input logic [OP_W-1:0]   op,
                                          input logic [OPND_W-1:0] a,
                                          input logic [OPND_W-1:0] b);
    logic signed [RES_W-1:0] ea;
    logic signed [RES_W-1:0] eb;
    logic signed [RES_W-1:0] r;
    golden_t                 g;
    ea = {a[OPND_W-1], a};
    eb = {b[OPND_W-1], b};
    r  = '0;
    case (op)
      OP_ADD:  r = ea + eb;
      OP_SUB:  r = ea - eb;
      OP_NEG:  r = -ea;
      OP_ABS:  r = ea[RES_W-1] ? -ea : ea;
      default: r = '0;
    endcase
    g.value = r;
    g.ovf   = (r > 5'sd7) || (r < -5'sd8);
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder.
// Ports:
//   seg_i   : active-low gfedcba pattern
//   valid_o : pattern is one of the known symbols
//   kind_o  : digit / minus / blank / 'E'
//   digit_o : digit value 0..8 when kind_o is KIND_DIGIT, else 0
module seg7_decode
  import calc_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             valid_o,
  output seg_kind_e        kind_o,
  output logic [3:0]       digit_o
);

  always_comb begin
    valid_o = 1'b1;
    kind_o  = KIND_DIGIT;
    digit_o = 4'd0;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_MINUS: kind_o  = KIND_MINUS;
      SEG_BLANK: kind_o  = KIND_BLANK;
      SEG_E:     kind_o  = KIND_E;
      default: begin
        valid_o = 1'b0;
        kind_o  = KIND_BLANK;
      end
    endcase
  end

endmodule

// File: rtl/calc_result_checker.sv
// Driver/checker for the 4-bit signed calculator's KEY/SW/HEX interface.
// Takes one {op,A,B} request, drives KEY/SW, waits SETTLE_CYCLES, samples
// HEX3/HEX2/HEX0, decodes them and compares against calc_golden.
// Ports:
//   CLOCK_50, RESET              : clock (rising edge), async active-high reset
//   req_valid/req_ready          : request handshake, ready only when idle
//   req_op, req_a, req_b         : request op code and signed operands
//   KEY, SW                      : op code and {A,B} driven to the calculator
//   HEX3, HEX2, HEX0             : sign, magnitude and overflow digits
//   done, pass                   : one-cycle verdict pulse and verdict
//   pass_cnt, fail_cnt           : saturating verdict tallies
//   fail_op, fail_a, fail_b      : first-failure capture
// Build option: define CALC_CHK_STICKY_EN to build the first-failure capture
// registers; otherwise fail_op/fail_a/fail_b are tied to zero.
module calc_result_checker
  import calc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [OPND_W-1:0]   req_a,
  input  logic [OPND_W-1:0]   req_b,
  output logic [OP_W-1:0]     KEY,
  output logic [2*OPND_W-1:0] SW,
  input  logic [SEG_W-1:0]    HEX3,
  input  logic [SEG_W-1:0]    HEX2,
  input  logic [SEG_W-1:0]    HEX0,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic [OP_W-1:0]     fail_op,
  output logic [OPND_W-1:0]   fail_a,
  output logic [OPND_W-1:0]   fail_b
);

  // DRIVE plus SETTLE together span SETTLE_CYCLES clocks; cnt_q counts SETTLE.
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e               state_q;
  logic [SET_W-1:0]     cnt_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 pass_q;
  logic [OP_W-1:0]      key_q;
  logic [2*OPND_W-1:0]  sw_q;
  logic [SEG_W-1:0]     hex3_q;
  logic [SEG_W-1:0]     hex2_q;
  logic [SEG_W-1:0]     hex0_q;
  logic [CNT_W-1:0]     pass_cnt_q;
  logic [CNT_W-1:0]     fail_cnt_q;
  logic [CNT_W-1:0]     pass_cnt_d;
  logic [CNT_W-1:0]     fail_cnt_d;

  // Decode of the sampled display digits
  logic       h3_valid, h2_valid, h0_valid;
  seg_kind_e  h3_kind, h2_kind, h0_kind;
  logic [3:0] h3_digit, h2_digit, h0_digit;

  seg7_decode u_dec_hex3 (.seg_i(hex3_q), .valid_o(h3_valid), .kind_o(h3_kind), .digit_o(h3_digit));
  seg7_decode u_dec_hex2 (.seg_i(hex2_q), .valid_o(h2_valid), .kind_o(h2_kind), .digit_o(h2_digit));
  seg7_decode u_dec_hex0 (.seg_i(hex0_q), .valid_o(h0_valid), .kind_o(h0_kind), .digit_o(h0_digit));

  // Sign and overflow digits only carry a kind, never a numeric value
  logic unused_digits;
  assign unused_digits = ^{h3_digit, h0_digit};

  // Verdict from the sampled display against the golden model
  golden_t                 golden;
  logic                    op_known;
  logic                    neg;
  logic                    sign_ok;
  logic                    mag_ok;
  logic                    ovf_shown;
  logic                    ovf_blank;
  logic signed [RES_W-1:0] dec_value;
  logic                    verdict_c;

  always_comb begin
    golden    = calc_golden(key_q, sw_q[2*OPND_W-1:OPND_W], sw_q[OPND_W-1:0]);
    op_known  = key_q inside {OP_ADD, OP_SUB, OP_NEG, OP_ABS};
    neg       = h3_valid && (h3_kind == KIND_MINUS);
    sign_ok   = h3_valid && ((h3_kind == KIND_MINUS) || (h3_kind == KIND_BLANK));
    // "-0" and "+8" are not legal renderings of a 4-bit result
    mag_ok    = h2_valid && (h2_kind == KIND_DIGIT) &&
                !(neg && (h2_digit == 4'd0)) && !(!neg && (h2_digit == 4'd8));
    dec_value = neg ? -RES_W'(h2_digit) : RES_W'(h2_digit);
    ovf_shown = h0_valid && (h0_kind == KIND_E);
    ovf_blank = h0_valid && (h0_kind == KIND_BLANK);
    verdict_c = 1'b0;
    if (!op_known) begin
      verdict_c = 1'b0;
    end else if (golden.ovf) begin
      verdict_c = ovf_shown;
    end else begin
      verdict_c = ovf_blank && sign_ok && mag_ok && (dec_value == golden.value);
    end
  end

  // Saturating increments
  always_comb begin
    pass_cnt_d = (&pass_cnt_q) ? pass_cnt_q : pass_cnt_q + CNT_W'(1);
    fail_cnt_d = (&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
  end

  // Request sequencing: IDLE -> DRIVE -> SETTLE -> SAMPLE -> REPORT -> IDLE
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      key_q      <= '0;
      sw_q       <= '0;
      hex3_q     <= SEG_BLANK;
      hex2_q     <= SEG_BLANK;
      hex0_q     <= SEG_BLANK;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            key_q   <= req_op;
            sw_q    <= {req_a, req_b};
            ready_q <= 1'b0;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          cnt_q   <= SET_W'(1);
          state_q <= (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + SET_W'(1);
          end
        end
        ST_SAMPLE: begin
          hex3_q  <= HEX3;
          hex2_q  <= HEX2;
          hex0_q  <= HEX0;
          state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          done_q  <= 1'b1;
          pass_q  <= verdict_c;
          if (verdict_c) begin
            pass_cnt_q <= pass_cnt_d;
          end else begin
            fail_cnt_q <= fail_cnt_d;
          end
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CALC_CHK_STICKY_EN
  logic [OP_W-1:0]   fail_op_q;
  logic [OPND_W-1:0] fail_a_q;
  logic [OPND_W-1:0] fail_b_q;

  // fail_cnt never wraps, so zero means no failure since reset
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      fail_op_q <= '0;
      fail_a_q  <= '0;
      fail_b_q  <= '0;
    end else if ((state_q == ST_REPORT) && !verdict_c && (fail_cnt_q == '0)) begin
      fail_op_q <= key_q;
      fail_a_q  <= sw_q[2*OPND_W-1:OPND_W];
      fail_b_q  <= sw_q[OPND_W-1:0];
    end
  end

  assign fail_op = fail_op_q;
  assign fail_a  = fail_a_q;
  assign fail_b  = fail_b_q;
`else
  assign fail_op = '0;
  assign fail_a  = '0;
  assign fail_b  = '0;
`endif

  assign req_ready = ready_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign KEY       = key_q;
  assign SW        = sw_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;

endmodule
